// File: rtl/multi_core_dbg_ctrl.sv
// Debug/program command engine for an N-core array: reset, memory write/read,
// bounded stepping, free run/halt and a saturating enabled-cycle counter.
module multi_core_dbg_ctrl #(
    parameter int NUM_CORES      = 4,
    parameter int DATA_WIDTH     = 64,
    parameter int MEM_ADDR_WIDTH = 10,
    parameter int STEP_WIDTH     = 32,
    parameter int RD_LATENCY     = 1,
    parameter int RST_CYCLES     = 4
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [31:0]                     sw_cmd,
    input  logic [NUM_CORES-1:0]            sw_core_mask,
    input  logic [MEM_ADDR_WIDTH-1:0]       sw_addr,
    input  logic [DATA_WIDTH-1:0]           sw_wdata,
    input  logic [STEP_WIDTH-1:0]           sw_step,
    output logic [NUM_CORES-1:0]            core_en,
    output logic [NUM_CORES-1:0]            core_reset,
    output logic [MEM_ADDR_WIDTH-1:0]       mem_addr,
    output logic [DATA_WIDTH-1:0]           mem_wdata,
    output logic [NUM_CORES-1:0]            mem_we,
    output logic [NUM_CORES-1:0]            mem_re,
    input  logic [NUM_CORES*DATA_WIDTH-1:0] mem_rdata,
    output logic [DATA_WIDTH-1:0]           rd_data,
    output logic                            busy,
    output logic                            done,
    output logic                            err,
    output logic [STEP_WIDTH-1:0]           cycle_count
);

    localparam int IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam int RC_W  = $clog2(RST_CYCLES + 1);
    localparam int RL_W  = $clog2(RD_LATENCY + 1);

    localparam logic [2:0] OP_RESET  = 3'd1;
    localparam logic [2:0] OP_WRITE  = 3'd2;
    localparam logic [2:0] OP_READ   = 3'd3;
    localparam logic [2:0] OP_STEP   = 3'd4;
    localparam logic [2:0] OP_RUN    = 3'd5;
    localparam logic [2:0] OP_HALT   = 3'd6;
    localparam logic [2:0] OP_CLRCNT = 3'd7;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_WR,
        S_RD_WAIT,
        S_STEP,
        S_RUN
    } state_t;

    state_t                  state;
    logic                    go_q;
    logic                    go_armed;
    logic [RC_W-1:0]         rst_cnt;
    logic [RL_W-1:0]         rd_cnt;
    logic [STEP_WIDTH-1:0]   step_cnt;
    logic [IDX_W-1:0]        rd_sel;
    logic [DATA_WIDTH-1:0]   core_rdata [NUM_CORES];

    logic       go_rise;
    logic [2:0] opcode;
    logic       needs_mask;
    logic       cmd_err;
    logic       unused_cmd_bits;

    assign unused_cmd_bits = ^sw_cmd[31:4];

    genvar c;
    for (c = 0; c < NUM_CORES; c++) begin : g_slice
        assign core_rdata[c] = mem_rdata[c*DATA_WIDTH +: DATA_WIDTH];
    end

    function automatic logic [IDX_W-1:0] lowest_idx(input logic [NUM_CORES-1:0] m);
        lowest_idx = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (m[i]) lowest_idx = IDX_W'(i);
        end
    endfunction

    // go_armed blocks a go that was already high when reset released.
    assign go_rise    = sw_cmd[0] & ~go_q & go_armed;
    assign opcode     = sw_cmd[3:1];
    assign needs_mask = (opcode >= OP_RESET) && (opcode <= OP_RUN);
    assign cmd_err    = go_rise && ((opcode == 3'd0) ||
                                    (needs_mask && (sw_core_mask == '0)) ||
                                    ((state != S_IDLE) && (opcode != OP_HALT) && (opcode != OP_CLRCNT)));
    assign busy       = (state != S_IDLE);

    // Command progress first, then a new go rise overrides it where they collide.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            go_q        <= 1'b0;
            go_armed    <= ~sw_cmd[0];
            rst_cnt     <= '0;
            rd_cnt      <= '0;
            step_cnt    <= '0;
            rd_sel      <= '0;
            core_en     <= '0;
            core_reset  <= '0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            mem_we      <= '0;
            mem_re      <= '0;
            rd_data     <= '0;
            done        <= 1'b0;
            err         <= 1'b0;
            cycle_count <= '0;
        end else begin
            go_q     <= sw_cmd[0];
            go_armed <= go_armed | ~sw_cmd[0];

            if ((|core_en) && !(&cycle_count)) cycle_count <= cycle_count + 1'b1;

            if (go_rise) begin
                done <= 1'b0;
                err  <= 1'b0;
            end

            case (state)
                S_RST: begin
                    if (rst_cnt == RC_W'(1)) begin
                        core_reset <= '0;
                        state      <= S_IDLE;
                        done       <= 1'b1;
                    end else begin
                        rst_cnt <= rst_cnt - 1'b1;
                    end
                end
                S_WR: begin
                    mem_we <= '0;
                    state  <= S_IDLE;
                    done   <= 1'b1;
                end
                S_RD_WAIT: begin
                    mem_re <= '0;
                    if (rd_cnt == RL_W'(RD_LATENCY)) begin
                        rd_data <= core_rdata[rd_sel];
                        state   <= S_IDLE;
                        done    <= 1'b1;
                    end else begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                S_STEP: begin
                    if (step_cnt == STEP_WIDTH'(1)) begin
                        core_en <= '0;
                        state   <= S_IDLE;
                        done    <= 1'b1;
                    end else begin
                        step_cnt <= step_cnt - 1'b1;
                    end
                end
                default: ;
            endcase

            if (cmd_err) begin
                err <= 1'b1;
            end else if (go_rise) begin
                case (opcode)
                    OP_RESET: begin
                        state       <= S_RST;
                        core_reset  <= sw_core_mask;
                        core_en     <= '0;
                        rst_cnt     <= RC_W'(RST_CYCLES);
                        cycle_count <= '0;
                    end
                    OP_WRITE: begin
                        state     <= S_WR;
                        mem_we    <= sw_core_mask;
                        mem_addr  <= sw_addr;
                        mem_wdata <= sw_wdata;
                    end
                    OP_READ: begin
                        state    <= S_RD_WAIT;
                        mem_re   <= sw_core_mask & (~sw_core_mask + NUM_CORES'(1));
                        mem_addr <= sw_addr;
                        rd_sel   <= lowest_idx(sw_core_mask);
                        rd_cnt   <= '0;
                    end
                    OP_STEP: begin
                        if (sw_step == '0) begin
                            done <= 1'b1;
                        end else begin
                            state    <= S_STEP;
                            core_en  <= sw_core_mask;
                            step_cnt <= sw_step;
                        end
                    end
                    OP_RUN: begin
                        state   <= S_RUN;
                        core_en <= sw_core_mask;
                    end
                    OP_HALT: begin
                        if ((state == S_RUN) || (state == S_STEP)) begin
                            core_en <= '0;
                            state   <= S_IDLE;
                            done    <= 1'b1;
                        end else if (state == S_IDLE) begin
                            done <= 1'b1;
                        end
                    end
                    OP_CLRCNT: begin
                        cycle_count <= '0;
                        done        <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_multi_core_dbg_ctrl.sv
// Directed self-checking bench for multi_core_dbg_ctrl with 4 cores, read latency 2
// and a 4-cycle core reset pulse.
module tb_multi_core_dbg_ctrl;

    logic         clk = 1'b0;
    logic         reset;
    logic [31:0]  sw_cmd;
    logic [3:0]   sw_core_mask;
    logic [9:0]   sw_addr;
    logic [63:0]  sw_wdata;
    logic [31:0]  sw_step;
    logic [3:0]   core_en;
    logic [3:0]   core_reset;
    logic [9:0]   mem_addr;
    logic [63:0]  mem_wdata;
    logic [3:0]   mem_we;
    logic [3:0]   mem_re;
    logic [255:0] mem_rdata;
    logic [63:0]  rd_data;
    logic         busy;
    logic         done;
    logic         err;
    logic [31:0]  cycle_count;

    int checks = 0;
    int errors = 0;

    logic [63:0] core_word [4];
    logic [3:0]  re_d1 = '0;
    logic [3:0]  re_d2 = '0;

    multi_core_dbg_ctrl #(
        .NUM_CORES(4), .DATA_WIDTH(64), .MEM_ADDR_WIDTH(10),
        .STEP_WIDTH(32), .RD_LATENCY(2), .RST_CYCLES(4)
    ) dut (
        .clk(clk), .reset(reset), .sw_cmd(sw_cmd), .sw_core_mask(sw_core_mask),
        .sw_addr(sw_addr), .sw_wdata(sw_wdata), .sw_step(sw_step),
        .core_en(core_en), .core_reset(core_reset), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_re(mem_re),
        .mem_rdata(mem_rdata), .rd_data(rd_data), .busy(busy), .done(done),
        .err(err), .cycle_count(cycle_count)
    );

    always #5 clk = ~clk;

    // Core memories answer two cycles after a read strobe; otherwise they drive junk.
    always @(posedge clk) begin
        re_d1 <= mem_re;
        re_d2 <= re_d1;
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            mem_rdata[i*64 +: 64] = re_d2[i] ? core_word[i] : 64'hBAD0_BAD0_BAD0_BAD0;
        end
    end

    // Raises go for one cycle; returns at the falling edge of the first action cycle.
    task automatic issue_cmd(input logic [2:0] op, input logic [3:0] mask,
                             input logic [9:0] addr, input logic [63:0] wdata,
                             input logic [31:0] step);
        @(negedge clk);
        sw_cmd       = {28'd0, op, 1'b1};
        sw_core_mask = mask;
        sw_addr      = addr;
        sw_wdata     = wdata;
        sw_step      = step;
        @(negedge clk);
        sw_cmd = 32'd0;
    endtask

    task automatic test_reset();
        reset        = 1'b1;
        sw_cmd       = 32'd0;
        sw_core_mask = '0;
        sw_addr      = '0;
        sw_wdata     = '0;
        sw_step      = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        checks++; if (core_en !== 4'h0) begin errors++; $display("[TB] FAIL reset_core_en: got %h expected 0", core_en); end
        checks++; if (core_reset !== 4'h0) begin errors++; $display("[TB] FAIL reset_core_reset: got %h expected 0", core_reset); end
        checks++; if ((mem_we | mem_re) !== 4'h0) begin errors++; $display("[TB] FAIL reset_strobes: got we=%h re=%h expected 0", mem_we, mem_re); end
        checks++; if ({busy, done, err} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got busy/done/err=%b expected 000", {busy, done, err}); end
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", cycle_count); end
        checks++; if (rd_data !== 64'd0) begin errors++; $display("[TB] FAIL reset_rd_data: got %h expected 0", rd_data); end
    endtask

    task automatic test_write();
        issue_cmd(3'd2, 4'b0101, 10'h03A, 64'hDEADBEEF_01234567, 32'd0);
        checks++; if (mem_we !== 4'b0101) begin errors++; $display("[TB] FAIL write_we: got %b expected 0101", mem_we); end
        checks++; if (mem_addr !== 10'h03A) begin errors++; $display("[TB] FAIL write_addr: got %h expected 03a", mem_addr); end
        checks++; if (mem_wdata !== 64'hDEADBEEF_01234567) begin errors++; $display("[TB] FAIL write_data: got %h expected deadbeef01234567", mem_wdata); end
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("[TB] FAIL write_busy: got busy/done=%b expected 10", {busy, done}); end
        @(negedge clk);
        checks++; if (mem_we !== 4'b0000) begin errors++; $display("[TB] FAIL write_we_drop: got %b expected 0000", mem_we); end
        checks++; if ({busy, done, err} !== 3'b010) begin errors++; $display("[TB] FAIL write_done: got busy/done/err=%b expected 010", {busy, done, err}); end
    endtask

    task automatic test_read();
        core_word[0] = 64'h1111;
        core_word[1] = 64'h55AA;
        core_word[2] = 64'h7777;
        core_word[3] = 64'h9999;
        issue_cmd(3'd3, 4'b0110, 10'h155, 64'd0, 32'd0);
        checks++; if (mem_re !== 4'b0010) begin errors++; $display("[TB] FAIL read_re: got %b expected 0010", mem_re); end
        checks++; if (mem_addr !== 10'h155) begin errors++; $display("[TB] FAIL read_addr: got %h expected 155", mem_addr); end
        @(negedge clk);
        checks++; if ({mem_re, busy} !== 5'b0000_1) begin errors++; $display("[TB] FAIL read_t2: got re/busy=%b expected 00001", {mem_re, busy}); end
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b10) begin errors++; $display("[TB] FAIL read_t3: got busy/done=%b expected 10", {busy, done}); end
        @(negedge clk);
        checks++; if (rd_data !== 64'h55AA) begin errors++; $display("[TB] FAIL read_data: got %h expected 55aa", rd_data); end
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("[TB] FAIL read_done: got busy/done=%b expected 01", {busy, done}); end
    endtask

    task automatic test_step();
        issue_cmd(3'd4, 4'b1111, 10'd0, 64'd0, 32'd5);
        for (int k = 1; k <= 7; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (core_en !== ((k <= 5) ? 4'hF : 4'h0)) begin
                errors++; $display("[TB] FAIL step_en_%0d: got %h expected %h", k, core_en, (k <= 5) ? 4'hF : 4'h0);
            end
            checks++;
            if (done !== (k >= 6)) begin
                errors++; $display("[TB] FAIL step_done_%0d: got %b expected %b", k, done, (k >= 6));
            end
        end
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("[TB] FAIL step_count: got %0d expected 5", cycle_count); end
        issue_cmd(3'd4, 4'b1111, 10'd0, 64'd0, 32'd0);
        checks++; if ({core_en, busy, done} !== 6'b0000_01) begin errors++; $display("[TB] FAIL step0: got en/busy/done=%b expected 000001", {core_en, busy, done}); end
        repeat (2) @(negedge clk);
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("[TB] FAIL step0_count: got %0d expected 5", cycle_count); end
    endtask

    task automatic test_run_halt();
        issue_cmd(3'd5, 4'b1111, 10'd0, 64'd0, 32'd0);
        checks++; if ({core_en, busy, done} !== 6'b1111_10) begin errors++; $display("[TB] FAIL run_start: got en/busy/done=%b expected 111110", {core_en, busy, done}); end
        repeat (8) @(negedge clk);
        checks++; if (cycle_count !== 32'd13) begin errors++; $display("[TB] FAIL run_mid_count: got %0d expected 13", cycle_count); end
        issue_cmd(3'd6, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if (core_en !== 4'h0) begin errors++; $display("[TB] FAIL halt_en: got %h expected 0", core_en); end
        checks++; if (cycle_count !== 32'd15) begin errors++; $display("[TB] FAIL halt_count: got %0d expected 15", cycle_count); end
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("[TB] FAIL halt_done: got busy/done=%b expected 01", {busy, done}); end
        issue_cmd(3'd7, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if ({cycle_count, done} !== {32'd0, 1'b1}) begin errors++; $display("[TB] FAIL clrcnt_idle: got count=%0d done=%b expected 0 1", cycle_count, done); end
        issue_cmd(3'd5, 4'b1111, 10'd0, 64'd0, 32'd0);
        issue_cmd(3'd2, 4'b0001, 10'h001, 64'h1, 32'd0);
        checks++; if ({err, mem_we} !== 5'b1_0000) begin errors++; $display("[TB] FAIL run_write_err: got err/we=%b expected 10000", {err, mem_we}); end
        checks++; if ({busy, core_en} !== 5'b1_1111) begin errors++; $display("[TB] FAIL run_write_state: got busy/en=%b expected 11111", {busy, core_en}); end
        @(negedge clk);
        checks++; if (mem_we !== 4'h0) begin errors++; $display("[TB] FAIL run_write_we: got %b expected 0000", mem_we); end
        issue_cmd(3'd6, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if (cycle_count !== 32'd5) begin errors++; $display("[TB] FAIL run2_count: got %0d expected 5", cycle_count); end
        checks++; if ({err, done, core_en} !== 6'b01_0000) begin errors++; $display("[TB] FAIL run2_halt: got err/done/en=%b expected 010000", {err, done, core_en}); end
    endtask

    task automatic test_errors();
        issue_cmd(3'd0, 4'b1111, 10'd0, 64'd0, 32'd0);
        checks++; if ({err, done, busy} !== 3'b100) begin errors++; $display("[TB] FAIL op0_flags: got err/done/busy=%b expected 100", {err, done, busy}); end
        checks++; if ({core_en, core_reset, mem_we, mem_re} !== 16'h0) begin errors++; $display("[TB] FAIL op0_outputs: got %h expected 0000", {core_en, core_reset, mem_we, mem_re}); end
        issue_cmd(3'd1, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if ({err, busy, core_reset} !== 6'b10_0000) begin errors++; $display("[TB] FAIL reset_mask0: got err/busy/rst=%b expected 100000", {err, busy, core_reset}); end
        issue_cmd(3'd1, 4'b0001, 10'd0, 64'd0, 32'd0);
        checks++; if ({err, busy, cycle_count} !== {2'b01, 32'd0}) begin errors++; $display("[TB] FAIL rstcmd_start: got err=%b busy=%b count=%0d expected 0 1 0", err, busy, cycle_count); end
        for (int k = 1; k <= 5; k++) begin
            if (k > 1) @(negedge clk);
            checks++;
            if (core_reset !== ((k <= 4) ? 4'b0001 : 4'b0000)) begin
                errors++; $display("[TB] FAIL rstcmd_pulse_%0d: got %b expected %b", k, core_reset, (k <= 4) ? 4'b0001 : 4'b0000);
            end
        end
        checks++; if ({busy, done} !== 2'b01) begin errors++; $display("[TB] FAIL rstcmd_done: got busy/done=%b expected 01", {busy, done}); end
    endtask

    task automatic test_back_to_back();
        issue_cmd(3'd5, 4'b0011, 10'd0, 64'd0, 32'd0);
        issue_cmd(3'd7, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if (cycle_count !== 32'd0) begin errors++; $display("[TB] FAIL b2b_clr: got %0d expected 0", cycle_count); end
        checks++; if ({busy, done, err, core_en} !== 7'b110_0011) begin errors++; $display("[TB] FAIL b2b_state: got %b expected 1100011", {busy, done, err, core_en}); end
        issue_cmd(3'd6, 4'b0000, 10'd0, 64'd0, 32'd0);
        checks++; if ({cycle_count, core_en} !== {32'd2, 4'h0}) begin errors++; $display("[TB] FAIL b2b_halt: got count=%0d en=%h expected 2 0", cycle_count, core_en); end
    endtask

    task automatic test_reset_mid_step();
        issue_cmd(3'd4, 4'b1111, 10'd0, 64'd0, 32'd100);
        repeat (19) @(negedge clk);
        checks++; if ({core_en, cycle_count} !== {4'hF, 32'd21}) begin errors++; $display("[TB] FAIL mid_step: got en=%h count=%0d expected f 21", core_en, cycle_count); end
        reset        = 1'b1;
        sw_cmd       = {28'd0, 3'd2, 1'b1};
        sw_core_mask = 4'b0001;
        @(negedge clk);
        checks++; if ({core_en, core_reset, mem_we, mem_re} !== 16'h0) begin errors++; $display("[TB] FAIL mid_reset_out: got %h expected 0000", {core_en, core_reset, mem_we, mem_re}); end
        checks++; if ({busy, done, err, cycle_count} !== 35'd0) begin errors++; $display("[TB] FAIL mid_reset_flags: got busy/done/err=%b count=%0d expected 000 0", {busy, done, err}, cycle_count); end
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if ({mem_we, busy, done} !== 6'b0) begin
                errors++; $display("[TB] FAIL held_go_%0d: got we/busy/done=%b expected 000000", k, {mem_we, busy, done});
            end
        end
        sw_cmd = 32'd0;
        issue_cmd(3'd2, 4'b0001, 10'h2AB, 64'hCAFE, 32'd0);
        checks++; if ({mem_we, mem_addr} !== {4'b0001, 10'h2AB}) begin errors++; $display("[TB] FAIL retoggle_write: got we=%b addr=%h expected 0001 2ab", mem_we, mem_addr); end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_step();
        test_run_halt();
        test_errors();
        test_back_to_back();
        test_reset_mid_step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
